// File: rtl/clk_div_pow2.sv
// clk_div_pow2: free-running power-of-two clock divider with wrap strobe and raw count
module clk_div_pow2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] cnt = '0;
    // Counter register: reset beats enable; the natural WIDTH-bit wrap ends each period
    always_ff @(posedge clk)
        if (!reset) cnt <= '0;
        else if (en) cnt <= cnt + WIDTH'(1);
    assign count   = cnt;
    assign clk_out = cnt[WIDTH-1];
    assign tick    = en & (&cnt);
endmodule

// File: tb/tb_clk_div_pow2.sv
// tb_clk_div_pow2: scoreboard bench for three divider widths against an arithmetic model
module tb_clk_div_pow2;
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic r8 = 1'b0, e8 = 1'b0, r4 = 1'b0, e4 = 1'b0, r1 = 1'b0, e1 = 1'b0;
    logic o8, t8, o4, t4, o1, t1;
    logic [7:0] c8;
    logic [3:0] c4;
    logic       c1;

    clk_div_pow2 #(.WIDTH(8)) dut8 (.clk(clk), .reset(r8), .en(e8), .clk_out(o8), .tick(t8), .count(c8));
    clk_div_pow2 #(.WIDTH(4)) dut4 (.clk(clk), .reset(r4), .en(e4), .clk_out(o4), .tick(t4), .count(c4));
    clk_div_pow2 #(.WIDTH(1)) dut1 (.clk(clk), .reset(r1), .en(e1), .clk_out(o1), .tick(t1), .count(c1));

    typedef struct {
        logic [7:0] c8; logic o8, t8;
        logic [3:0] c4; logic o4, t4;
        logic       c1; logic o1, t1;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0, n = 0;
    int m8 = 0, m4 = 0, m1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count is the number of enabled cycles since reset, modulo 2^W; clk_out is "upper half"
    function automatic exp_t model();
        exp_t e;
        e.c8 = 8'(m8 % 256); e.o8 = (m8 % 256) >= 128; e.t8 = e8 && (m8 % 256) == 255;
        e.c4 = 4'(m4 % 16);  e.o4 = (m4 % 16) >= 8;    e.t4 = e4 && (m4 % 16) == 15;
        e.c1 = 1'(m1 % 2);   e.o1 = (m1 % 2) >= 1;     e.t1 = e1 && (m1 % 2) == 1;
        return e;
    endfunction

    task automatic step(input logic rr8, input logic ee8);
        r8 = rr8;
        e8 = ee8;
        r1 = (n >= 3);
        e1 = 1'b1;
        r4 = (n < 3) ? 1'b0 : ($urandom_range(0, 19) != 0);
        e4 = ($urandom_range(0, 3) != 0);
        q.push_back(model());
        @(posedge clk);
        m8 = !r8 ? 0 : m8 + (e8 ? 1 : 0);
        m4 = !r4 ? 0 : m4 + (e4 ? 1 : 0);
        m1 = !r1 ? 0 : m1 + (e1 ? 1 : 0);
        #1;
        n++;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation
    always @(negedge clk)
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("count8", 32'(c8), 32'(e.c8));
            chk("clk_out8", 32'(o8), 32'(e.o8));
            chk("tick8", 32'(t8), 32'(e.t8));
            chk("count4", 32'(c4), 32'(e.c4));
            chk("clk_out4", 32'(o4), 32'(e.o4));
            chk("clk_out4_msb", 32'(o4), 32'(c4[3]));
            chk("tick4", 32'(t4), 32'(e.t4));
            chk("count1", 32'(c1), 32'(e.c1));
            chk("clk_out1", 32'(o1), 32'(e.o1));
            chk("tick1", 32'(t1), 32'(e.t1));
        end

    initial begin
        repeat (3) step(1'b0, 1'b1);
        repeat (300) step(1'b1, 1'b1);
        for (int k = 0; k < 600 && (m8 % 256) != 100; k++) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (300) step(1'b1, 1'b1);
        for (int k = 0; k < 600 && (m8 % 256) != 200; k++) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        repeat (50) step(1'b1, 1'b1);
        repeat (200) step($urandom_range(0, 29) != 0, $urandom_range(0, 3) != 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
